// File: rtl/mmio_uart_tx_if.sv
// Memory-stage bus seen by the MMIO UART transmitter: store strobe, address,
// store data, and the block's read data / window-hit indication back to the core.
interface mmio_uart_tx_if;
    logic        MemWrite;
    logic [31:0] ALUResult;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        sel;

    modport master (
        output MemWrite,
        output ALUResult,
        output WriteData,
        input  ReadData,
        input  sel
    );

    modport slave (
        input  MemWrite,
        input  ALUResult,
        input  WriteData,
        output ReadData,
        output sel
    );
endinterface

// File: rtl/mmio_uart_tx.sv
// MMIO UART transmitter: TXDATA/STATUS register window feeding a TX FIFO and an
// 8N1 serialiser. Define UART_TX_PARITY_EN to add an even-parity bit (8E1 frame).
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic           clk,
    input  logic           reset,
    mmio_uart_tx_if.slave  bus,
    output logic           tx
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } state_t;

    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction

    logic           wr_data_s;
    logic           wr_stat_s;
    logic           full_s;
    logic           empty_s;
    logic           push_s;
    logic           pop_s;
    logic           busy_s;
    logic           last_s;
    logic [7:0]     cnt8_s;
    logic [31:0]    status_s;
    logic           unused_s;

    logic [7:0]     mem_r [FIFO_DEPTH];
    logic [PW-1:0]  wr_ptr_r;
    logic [PW-1:0]  rd_ptr_r;
    logic [CW-1:0]  count_r;
    logic           ovf_r;

    state_t         state_r;
    state_t         state_n;
    logic [BW-1:0]  baud_r;
    logic [BW-1:0]  baud_n;
    logic [2:0]     bit_r;
    logic [2:0]     bit_n;
    logic [7:0]     shift_r;
    logic [7:0]     shift_n;
    logic           tx_r;
    logic           tx_n;

    assign bus.sel   = (bus.ALUResult[31:3] == BASE_ADDR[31:3]);
    assign wr_data_s = bus.MemWrite & bus.sel & ~bus.ALUResult[2];
    assign wr_stat_s = bus.MemWrite & bus.sel &  bus.ALUResult[2];
    assign full_s    = (count_r == CW'(FIFO_DEPTH));
    assign empty_s   = (count_r == CW'(0));
    // Full is judged on registered state, so a same-cycle pop never rescues a push.
    assign push_s    = wr_data_s & ~full_s;
    assign busy_s    = (state_r != ST_IDLE);
    assign last_s    = (baud_r == BW'(CLKS_PER_BIT - 1));
    assign cnt8_s    = 8'(count_r);
    assign status_s  = {16'h0000, cnt8_s, 4'h0, ovf_r, busy_s, empty_s, full_s};
    assign unused_s  = &{1'b0, bus.WriteData[31:8], bus.ALUResult[1:0]};
    assign tx        = tx_r;

    // Register read mux: only STATUS returns data, everything else reads as zero.
    always_comb begin
        bus.ReadData = 32'h0000_0000;
        if (bus.sel && bus.ALUResult[2]) begin
            bus.ReadData = status_s;
        end else begin
            bus.ReadData = 32'h0000_0000;
        end
    end

    // FIFO storage; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= bus.WriteData[7:0];
        end
    end

    // FIFO pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            ovf_r    <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
            if (wr_data_s && full_s) begin
                ovf_r <= 1'b1;
            end else if (wr_stat_s && bus.WriteData[3]) begin
                ovf_r <= 1'b0;
            end
        end
    end

    // Serialiser state register; tx is registered from the next-state decode.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            baud_r  <= '0;
            bit_r   <= 3'd0;
            shift_r <= 8'h00;
            tx_r    <= 1'b1;
        end else begin
            state_r <= state_n;
            baud_r  <= baud_n;
            bit_r   <= bit_n;
            shift_r <= shift_n;
            tx_r    <= tx_n;
        end
    end

    // Next-state, baud/bit counting and FIFO pop decisions.
    always_comb begin
        state_n = state_r;
        baud_n  = baud_r;
        bit_n   = bit_r;
        shift_n = shift_r;
        pop_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                baud_n = '0;
                bit_n  = 3'd0;
                if (!empty_s) begin
                    pop_s   = 1'b1;
                    shift_n = mem_r[rd_ptr_r];
                    state_n = ST_START;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_START: begin
                if (last_s) begin
                    baud_n  = '0;
                    bit_n   = 3'd0;
                    state_n = ST_DATA;
                end else begin
                    baud_n = baud_r + BW'(1);
                end
            end
            ST_DATA: begin
                if (last_s) begin
                    baud_n = '0;
                    if (bit_r == 3'd7) begin
                        bit_n = 3'd0;
`ifdef UART_TX_PARITY_EN
                        state_n = ST_PARITY;
`else
                        state_n = ST_STOP;
`endif
                    end else begin
                        bit_n = bit_r + 3'd1;
                    end
                end else begin
                    baud_n = baud_r + BW'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (last_s) begin
                    baud_n  = '0;
                    state_n = ST_STOP;
                end else begin
                    baud_n = baud_r + BW'(1);
                end
            end
`endif
            ST_STOP: begin
                if (last_s) begin
                    baud_n = '0;
                    bit_n  = 3'd0;
                    // Chain straight into the next start bit so frames stay contiguous.
                    if (!empty_s) begin
                        pop_s   = 1'b1;
                        shift_n = mem_r[rd_ptr_r];
                        state_n = ST_START;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end else begin
                    baud_n = baud_r + BW'(1);
                end
            end
            default: begin
                state_n = ST_IDLE;
                baud_n  = '0;
                bit_n   = 3'd0;
            end
        endcase
    end

    // Line level for the state being entered.
    always_comb begin
        tx_n = 1'b1;
        case (state_n)
            ST_IDLE:   tx_n = 1'b1;
            ST_START:  tx_n = 1'b0;
            ST_DATA:   tx_n = shift_n[bit_n];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx_n = even_parity(shift_n);
`endif
            ST_STOP:   tx_n = 1'b1;
            default:   tx_n = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx: register window, serial framing, FIFO overflow,
// overflow clear, address miss, mid-frame reset and (when enabled) parity.
module tb_mmio_uart_tx;

    localparam logic [31:0] BASE = 32'h0000_1000;
    localparam int          CPB  = 4;
`ifdef UART_TX_PARITY_EN
    localparam int          NB   = 11;
`else
    localparam int          NB   = 10;
`endif
    localparam int          FLEN = NB * CPB;

    logic clk = 1'b0;
    logic reset;
    logic tx;
    int   vec_cnt = 0;
    int   err_cnt = 0;
    bit   cap_en  = 1'b0;
    logic txq[$];

    mmio_uart_tx_if bus_if ();

    mmio_uart_tx #(
        .BASE_ADDR    (BASE),
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if),
        .tx    (tx)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cap_en) txq.push_back(tx);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic fbit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        else if (idx <= 8) return b[idx-1];
`ifdef UART_TX_PARITY_EN
        else if (idx == 9) return ^b;
`endif
        else return 1'b1;
    endfunction

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        bus_if.MemWrite  = 1'b1;
        bus_if.ALUResult = addr;
        bus_if.WriteData = data;
        @(negedge clk);
        bus_if.MemWrite  = 1'b0;
        bus_if.ALUResult = 32'h0000_0000;
        bus_if.WriteData = 32'h0000_0000;
    endtask

    task automatic rd(input logic [31:0] addr, output logic [31:0] d);
        bus_if.ALUResult = addr;
        #1;
        d = bus_if.ReadData;
    endtask

    // Called at the negedge following the accepting edge E0; samples after E1..E(FLEN).
    task automatic check_frame(input logic [7:0] b, input string tag);
        logic [31:0] d;
        for (int i = 0; i < FLEN; i++) begin
            @(negedge clk);
            chk(tag, {31'b0, tx}, {31'b0, fbit(b, i / CPB)});
            if ((i % CPB) == 1) begin
                rd(BASE + 32'd4, d);
                chk({tag, "_busy"}, {31'b0, d[2]}, 32'h0000_0001);
            end
        end
    endtask

    initial begin
        logic [31:0] d;
        int          s;
        int          idx;
        logic        ob;

        reset            = 1'b0;
        bus_if.MemWrite  = 1'b0;
        bus_if.ALUResult = 32'h0000_0000;
        bus_if.WriteData = 32'h0000_0000;

        // Reset
        repeat (2) @(negedge clk);
        chk("rst_tx_during", {31'b0, tx}, 32'h0000_0001);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_tx", {31'b0, tx}, 32'h0000_0001);
        rd(BASE + 32'd4, d);
        chk("rst_status", d, 32'h0000_0002);
        chk("rst_sel_hit", {31'b0, bus_if.sel}, 32'h0000_0001);
        rd(BASE, d);
        chk("rst_txdata_rd", d, 32'h0000_0000);
        rd(32'h0000_0000, d);
        chk("rst_miss_rd", d, 32'h0000_0000);
        chk("rst_miss_sel", {31'b0, bus_if.sel}, 32'h0000_0000);

        // Single byte 0x55
        wr(BASE, 32'h0000_0055);
        chk("b55_tx_e0", {31'b0, tx}, 32'h0000_0001);
        rd(BASE + 32'd4, d);
        chk("b55_status_e0", d, 32'h0000_0100);
        check_frame(8'h55, "b55_frame");
        @(negedge clk);
        chk("b55_tx_after", {31'b0, tx}, 32'h0000_0001);
        rd(BASE + 32'd4, d);
        chk("b55_status_after", d, 32'h0000_0002);

        // Ten back-to-back writes into an 8-deep FIFO
        txq.delete();
        cap_en = 1'b1;
        for (int k = 0; k < 10; k++) wr(BASE, k);
        rd(BASE + 32'd4, d);
        chk("ovf_status", d, 32'h0000_080D);
        wr(BASE + 32'd4, 32'h0000_0000);
        rd(BASE + 32'd4, d);
        chk("ovf_clr0_status", d, 32'h0000_080D);
        wr(BASE + 32'd4, 32'h0000_0008);
        rd(BASE + 32'd4, d);
        chk("ovf_clr8_status", d, 32'h0000_0805);

        // Address miss
        bus_if.MemWrite  = 1'b1;
        bus_if.ALUResult = BASE + 32'd8;
        bus_if.WriteData = 32'h0000_00AA;
        #1;
        chk("miss_sel", {31'b0, bus_if.sel}, 32'h0000_0000);
        chk("miss_rd", bus_if.ReadData, 32'h0000_0000);
        @(negedge clk);
        bus_if.MemWrite  = 1'b0;
        rd(BASE + 32'd4, d);
        chk("miss_status", d, 32'h0000_0805);

        // Let the nine accepted bytes drain, then decode the captured line
        repeat (9 * FLEN + 10) @(negedge clk);
        cap_en = 1'b0;
        s = -1;
        for (int i = 0; i < txq.size(); i++) begin
            if (s < 0 && txq[i] === 1'b0) s = i;
        end
        chk("ovf_start_found", {31'b0, (s >= 0)}, 32'h0000_0001);
        if (s < 0) s = 0;
        for (int k = 0; k < 9; k++) begin
            for (int i = 0; i < FLEN; i++) begin
                idx = s + k * FLEN + i;
                ob  = (idx < txq.size()) ? txq[idx] : 1'bx;
                chk("ovf_stream", {31'b0, ob}, {31'b0, fbit(8'(k), i / CPB)});
            end
        end
        for (int i = 0; i < 8; i++) begin
            idx = s + 9 * FLEN + i;
            ob  = (idx < txq.size()) ? txq[idx] : 1'bx;
            chk("ovf_trail_idle", {31'b0, ob}, 32'h0000_0001);
        end
        rd(BASE + 32'd4, d);
        chk("ovf_drained_status", d, 32'h0000_0002);

        // Mid-frame reset during data bit 3 of 0xF0 with three bytes queued
        wr(BASE, 32'h0000_00F0);
        wr(BASE, 32'h0000_0011);
        wr(BASE, 32'h0000_0022);
        wr(BASE, 32'h0000_0033);
        repeat (15) @(negedge clk);
        chk("mrst_bit3", {31'b0, tx}, 32'h0000_0000);
        rd(BASE + 32'd4, d);
        chk("mrst_status_pre", d, 32'h0000_0304);
        reset = 1'b0;
        @(negedge clk);
        chk("mrst_tx", {31'b0, tx}, 32'h0000_0001);
        reset = 1'b1;
        @(negedge clk);
        rd(BASE + 32'd4, d);
        chk("mrst_status_post", d, 32'h0000_0002);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("mrst_idle", {31'b0, tx}, 32'h0000_0001);
        end

`ifdef UART_TX_PARITY_EN
        // Parity frame for 0x07
        wr(BASE, 32'h0000_0007);
        check_frame(8'h07, "par07_frame");
        @(negedge clk);
        chk("par07_tx_after", {31'b0, tx}, 32'h0000_0001);
        rd(BASE + 32'd4, d);
        chk("par07_status_after", d, 32'h0000_0002);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/mmio_uart_tx.md
# mmio_uart_tx

Memory-mapped UART transmitter that sits directly downstream of the pipelined core's data-memory port. It consumes the core's memory-stage outputs (MemWrite, ALUResult as address, WriteData) and produces ReadData for its own address window. Written bytes are queued in a FIFO and serialised 8N1, LSB first, on `tx`. The top level uses `sel` to mux this block's ReadData against data memory.

## Interface
- BASE_ADDR, 32'h0000_1000, base of the 8-byte register window; bits [2:0] must be 0
- CLKS_PER_BIT, 16, clock cycles per serial bit; minimum 2
- FIFO_DEPTH, 8, TX FIFO entries; power of 2, 2..128

- clk  in  1  core clock
- reset  in  1  synchronous, active-low reset
- MemWrite  in  1  store strobe from the memory stage
- ALUResult  in  32  byte address from the memory stage
- WriteData  in  32  store data; only [7:0] or [3] used
- ReadData  out  32  register read data, combinational; 0 when `sel`=0
- sel  out  1  combinational; 1 when ALUResult[31:3]==BASE_ADDR[31:3]
- tx  out  1  serial output, registered, idle high

## Operation
- Decode: `sel` per above; ALUResult[2] selects register; ALUResult[1:0] ignored.
- BASE+0 TXDATA: a write pushes WriteData[7:0]. Reads return 0.
- BASE+4 STATUS reads: [0] full, [1] empty, [2] busy (FSM not IDLE), [3] overflow (sticky), [15:8] FIFO count, others 0. A write with WriteData[3]=1 clears overflow; all other write bits are ignored.
- Push while full: byte dropped, overflow set. Full is evaluated before any same-cycle pop, so a push on a full FIFO is dropped even if a pop happens in that cycle.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If the FIFO is non-empty: pop head into the shift register, load the bit counter, go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: 8 bits, LSB first, each CLKS_PER_BIT cycles; a 3-bit index counts 0..7.
  - STOP: tx=1 for CLKS_PER_BIT cycles. Then, if the FIFO is non-empty, pop and go to START (back-to-back frames, no gap); otherwise go to IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1 and resets on every state or bit change.
- FIFO: circular, read and write pointers wrap modulo FIFO_DEPTH; count is tracked separately. Push and pop in the same cycle on a non-full FIFO leave the count unchanged.
- Reset values: tx=1, state IDLE, FIFO empty (count 0), overflow 0, counters 0, ReadData=0.
- Reset asserted mid-frame: the frame is aborted, tx=1 after the next edge, and the FIFO is flushed.

## Timing
- Write accepted at edge E0 (MemWrite high in the cycle before E0); count and STATUS reflect it immediately after E0.
- If IDLE with an empty FIFO before E0: pop at E1, and tx falls to 0 after E1.
- Frame length is 10×CLKS_PER_BIT cycles (11× with parity). Consecutive queued bytes are contiguous on `tx`.
- STATUS read is combinational and reflects register state as of the last edge.

## Configuration
- UART_TX_PARITY_EN defined: adds a PARITY state between DATA and STOP. It drives even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles; the frame is 11 bits.
- UART_TX_PARITY_EN undefined: no PARITY state; 8N1, 10-bit frame.

## Test plan
- Reset low for 2 cycles, then high: tx=1, STATUS read at BASE+4 = 32'h0000_0002, ReadData=0 at any non-window address.
- CLKS_PER_BIT=4, write 8'h55 to BASE+0:
  - tx low 4 cycles starting after E1.
  - Then 1,0,1,0,1,0,1,0, each 4 cycles.
  - Then stop=1 for 4 cycles; 40 cycles total.
  - Busy=1 throughout, then STATUS returns to 32'h0000_0002.
- FIFO_DEPTH=8, 10 consecutive TXDATA writes 8'h00..8'h09:
  - 9 accepted; 8'h09 dropped.
  - STATUS = 32'h0000_080D (count 8, overflow, busy, full).
  - tx emits 00..08 contiguously.
- Overflow clear: write 32'h0 to BASE+4 → overflow stays 1; write 32'h8 → STATUS[3]=0, FIFO unaffected.
- Address miss: MemWrite to BASE+8 with 8'hAA → sel=0, no push, count unchanged, ReadData=0.
- Mid-frame reset during the DATA bit 3 of 8'hF0 with 3 bytes queued: tx=1 the cycle after reset, STATUS=32'h0000_0002 after release.
- UART_TX_PARITY_EN defined, write 8'h07: parity bit 1 after bit 7, 44-cycle frame.
